ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 71 +++++++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes and the
// odd-parity helper used when framing a command.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    XFER,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line with an optional 8-cycle
// level filter and a falling-edge strobe. Shared with the receiver path.
module ps2_line_sync #(
  parameter bit FILTER_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = level;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  generate
    if (FILTER_EN) begin : g_filter
      logic       filt_q, filt_d;
      logic [2:0] run_q, run_d;

      // The filtered level flips only on the 8th consecutive disagreeing sample.
      always_comb begin
        filt_d = filt_q;
        run_d  = 3'd0;
        if (sync_q != filt_q) begin
          if (run_q == 3'd7) begin
            filt_d = sync_q;
          end else begin
            run_d = run_q + 3'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          filt_q <= 1'b1;
          run_q  <= 3'd0;
        end else begin
          filt_q <= filt_d;
          run_q  <= run_d;
        end
      end

      assign level = filt_q;
    end else begin : g_raw
      assign level = sync_q;
    end
  endgenerate

  assign fall = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data enables.
// Define PS2_TX_GLITCH_FILTER_EN to add an 8-cycle glitch filter on the PS/2 clock.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam bit CLK_FILTER_EN = 1'b1;
`else
  localparam bit CLK_FILTER_EN = 1'b0;
`endif

  // The device only notices a request-to-send after at least 100 us of clock inhibit.
  generate
    if (INHIBIT_CYCLES * 10000 < CLK_FREQ_HZ) begin : g_bad_inhibit
      $error("INHIBIT_CYCLES is shorter than 100 us at CLK_FREQ_HZ");
    end
  endgenerate

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shreg_q, shreg_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_ok_q, ack_ok_d;
  logic             data_meta_q, data_meta_d;
  logic             data_sync_q, data_sync_d;
  logic             clk_level, clk_fall;
  logic             timed_out;

  ps2_line_sync #(
    .FILTER_EN (CLK_FILTER_EN)
  ) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  assign timed_out = ((state_q == XFER) || (state_q == ACK) || (state_q == WAIT_IDLE))
                     && (cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_oe_d   = data_oe_q;
    ack_ok_d    = ack_ok_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;

    if (timed_out) begin
      data_oe_d = 1'b0;
      ack_ok_d  = 1'b0;
      state_d   = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          data_oe_d = 1'b0;
          if (tx_valid) begin
            shreg_d   = {1'b1, odd_parity(tx_data), tx_data};
            bit_cnt_d = 4'd0;
            cnt_d     = '0;
            state_d   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            data_oe_d = 1'b1;
            cnt_d     = '0;
            state_d   = XFER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        XFER: begin
          cnt_d = cnt_q + 1'b1;
          // Shifting in a zero means the stop bit (1) ends up releasing the line.
          if (clk_fall) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) begin
              state_d = ACK;
            end
          end
        end
        ACK: begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fall) begin
            ack_ok_d = ~data_sync_q;
            state_d  = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          cnt_d = cnt_q + 1'b1;
          if (clk_level && data_sync_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= '0;
      data_oe_q   <= 1'b0;
      ack_ok_q    <= 1'b0;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_oe_q   <= data_oe_d;
      ack_ok_q    <= ack_ok_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  // Clock enable decodes straight from state so an async reset releases it at once.
  assign ps2_clk_oe  = (state_q == INHIBIT);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_ack_ok   = tx_done & ack_ok_q;
  assign tx_error    = tx_done & ~ack_ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// scoreboard of queued commands is checked against each tx_done.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ack;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] got_q[$];
  int         err_cnt = 0;
  int         chk_cnt = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (500000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_ack_ok   (tx_ack_ok),
    .tx_error    (tx_error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic ack);
    exp_t e;
    e.data   = d;
    e.parity = ~^d;
    e.ack    = ack;
    exp_q.push_back(e);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard side: measures the inhibit, clocks n_falls bits out and optionally ACKs.
  task automatic deviceModel(input logic give_ack, input int n_falls, input logic glitch);
    int n;
    logic [9:0] bits;
    bits = '0;
    n = 0;
    while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_oe && n < INH + 200) begin @(negedge clk); n++; end
    checkOutput("inhibit_len", n, INH);
    checkOutput("start_bit", {30'd0, ps2_data_oe, ps2_data_in}, 32'h2);
    for (int k = 0; k < n_falls; k++) begin
      if (glitch && k == 2) begin
        repeat (HALF / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bits[k] = ps2_data_in;
      dev_clk = 1'b1;
    end
    if (n_falls == 10) begin
      got_q.push_back(bits);
      repeat (HALF / 2) @(negedge clk);
      if (give_ack) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic waitDone(input int budget, input logic exp_timeout);
    int n;
    exp_t e;
    logic [9:0] g;
    n = 0;
    while (!tx_done && n < budget) begin @(negedge clk); n++; end
    if (!tx_done) begin
      checkOutput("done_seen", 0, 1);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("ack_ok", {31'd0, tx_ack_ok}, {31'd0, e.ack});
        checkOutput("error", {31'd0, tx_error}, {31'd0, ~e.ack});
        if (!exp_timeout) begin
          if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checkOutput("data_bits", {24'd0, g[7:0]}, {24'd0, e.data});
            checkOutput("parity_bit", {31'd0, g[8]}, {31'd0, e.parity});
            checkOutput("stop_bit", {31'd0, g[9]}, 32'd1);
          end else begin
            checkOutput("bits_seen", 0, 1);
          end
        end
      end else begin
        checkOutput("scoreboard_empty", 0, 1);
      end
      checkOutput("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      @(negedge clk);
      checkOutput("done_pulse", {29'd0, tx_done, tx_ready, busy}, 32'h2);
    end
  endtask

  task automatic runFrame(input logic [7:0] d, input logic ack, input logic glitch, input logic poke);
    applyStimulus(d, ack);
    fork
      deviceModel(ack, 10, glitch);
      waitDone(5000, 1'b0);
      if (poke) begin
        repeat (INH + 200) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        checkOutput("ready_busy_xfer", {30'd0, tx_ready, busy}, 32'h1);
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {25'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_ack_ok, tx_error},
                32'h40);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    runFrame(PS2_CMD_SET_LEDS, 1'b1, 1'b0, 1'b0);
    runFrame(8'h07, 1'b1, 1'b0, 1'b0);
    runFrame(8'h00, 1'b1, 1'b0, 1'b0);
    runFrame(8'hA5, 1'b0, 1'b0, 1'b0);

    // Device goes silent after the clock is released.
    applyStimulus(PS2_CMD_RESET, 1'b0);
    deviceModel(1'b0, 0, 1'b0);
    n = 0;
    while (ps2_data_oe && n < TMO + 100) begin @(negedge clk); n++; end
    checkOutput("timeout_len", n, TMO);
    waitDone(10, 1'b1);
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame.
    applyStimulus(8'h00, 1'b1);
    deviceModel(1'b1, 4, 1'b0);
    checkOutput("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_frame", {27'd0, ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done}, 32'h4);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    got_q.delete();
    repeat (3) @(negedge clk);

    runFrame(PS2_CMD_ENABLE, 1'b1, 1'b0, 1'b1);
    checkOutput("idle_after_poke", {30'd0, tx_ready, busy}, 32'h2);
`ifdef PS2_TX_GLITCH_FILTER_EN
    runFrame(PS2_CMD_RESET, 1'b1, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
